// File: rtl/pm2_seq_div_if.sv
// Start/busy/done handshake bundle for the pm2 sequential divider.
// The master issues operands and start; the slave returns results.
interface pm2_seq_div_if #(
  parameter int DW = 4,
  parameter int VW = 2
);
  logic          start;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          busy;
  logic          done;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/pm2_seq_div.sv
// Restoring divider inverting pm2: DW-bit dividend over VW-bit divisor.
// Produces one quotient bit per clock; a zero divisor completes on the next edge.
module pm2_seq_div #(
  parameter int DW = 4,
  parameter int VW = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  pm2_seq_div_if.slave  bus
);
  localparam int CW = $clog2(DW + 1);

  typedef enum logic [0:0] {IDLE = 1'b0, CALC = 1'b1} state_e;

  state_e        state_q;
  logic [DW-1:0] q_q;
  logic [VW-1:0] d_q;
  logic [VW-1:0] r_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;
  logic          done_q;
  logic [DW-1:0] quot_q;
  logic [VW-1:0] rem_q;
  logic          dbz_q;

  logic [VW:0]   t_s;
  logic          ge_s;
  logic [DW-1:0] q_d;
  logic [VW-1:0] r_d;

  // One restoring step; the remainder stays below the divisor so VW bits hold it.
  always_comb begin
    t_s  = {r_q, q_q[DW-1]};
    ge_s = (t_s >= {1'b0, d_q});
    q_d  = {q_q[DW-2:0], ge_s};
    if (ge_s) begin
      r_d = VW'(t_s - {1'b0, d_q});
    end else begin
      r_d = t_s[VW-1:0];
    end
  end

  // Control FSM with operand capture, stepping and registered results.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      q_q     <= {DW{1'b0}};
      d_q     <= {VW{1'b0}};
      r_q     <= {VW{1'b0}};
      cnt_q   <= {CW{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= {DW{1'b0}};
      rem_q   <= {VW{1'b0}};
      dbz_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            q_q     <= bus.dividend;
            d_q     <= bus.divisor;
            r_q     <= {VW{1'b0}};
            cnt_q   <= CW'(DW);
            busy_q  <= 1'b1;
            state_q <= CALC;
          end
        end
        CALC: begin
          if (d_q == {VW{1'b0}}) begin
            quot_q  <= {DW{1'b1}};
            rem_q   <= {VW{1'b0}};
            dbz_q   <= 1'b1;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            cnt_q   <= {CW{1'b0}};
            state_q <= IDLE;
          end else begin
            q_q   <= q_d;
            r_q   <= r_d;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
              quot_q  <= q_d;
              rem_q   <= r_d;
              dbz_q   <= 1'b0;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: doc/pm2_seq_div.md
# pm2_seq_div

Sequential restoring divider that inverts the `pm2` 2-bit multiplier. It takes a DW-bit product-width dividend and a VW-bit operand-width divisor, and returns quotient, remainder and a divide-by-zero flag. It uses a start/busy/done handshake and produces one quotient bit per clock. It sits beside `pm2` so a bench can check a product against its operand, and it serves as the low-activity counterpart in power runs.

## Interface
- DW, 4, dividend and quotient width (product width of `pm2`).
- VW, 2, divisor and remainder width (operand width of `pm2`); must satisfy VW <= DW.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous and active-high; clears all state and outputs immediately.
- start  input  1  request; sampled only when busy=0.
- dividend  input  DW  numerator; captured on the accepting edge.
- divisor  input  VW  denominator; captured on the accepting edge.
- busy  output  1  high while a division is in progress.
- done  output  1  one-cycle pulse when results become valid.
- quotient  output  DW  registered result; held until the next completion.
- remainder  output  VW  registered result; held until the next completion.
- div_by_zero  output  1  registered flag; set with done when divisor==0, otherwise cleared with done.

## Operation
- States: IDLE, CALC.
- IDLE:
  - If start=1, capture dividend into shift register Q and divisor into D.
  - Clear the partial remainder R (VW+1 bits).
  - Load step counter with DW, set busy=1 and go to CALC.
  - If the captured divisor is 0, go to IDLE instead on the next edge and take the zero path.
- CALC step (one per edge):
  - Form T = {R[VW-1:0], Q[DW-1]}.
  - If T >= D: R = T - D and shift 1 into Q LSB. Otherwise R = T and shift 0 into Q LSB.
  - Decrement the counter.
- When the counter reaches 0 after the DW-th step:
  - quotient <= Q, remainder <= R[VW-1:0], div_by_zero <= 0.
  - done <= 1, busy <= 0, go to IDLE.
- Zero path, on the edge after acceptance:
  - quotient <= all ones, remainder <= 0, div_by_zero <= 1.
  - done <= 1, busy <= 0, state IDLE.
- Arithmetic is unsigned. The compare/subtract uses VW+1 bits, so there is no overflow. The remainder is always < divisor.
- start while busy=1 is ignored; it is neither queued nor allowed to corrupt operands.
- Operand inputs may change freely after the accepting edge.
- quotient, remainder and div_by_zero update only together with done and hold otherwise.

## Timing
- Reset values: busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, state IDLE, counter 0.
- Accepting edge E0 (start=1, busy=0):
  - busy=1 from E0.
  - Normal latency: steps occur on E1..E_DW. Results and done=1 appear at E_DW, and busy=0 at E_DW. For DW=4, done is high in the 4th cycle after E0.
  - Divide-by-zero latency: done at E1.
- done is high for exactly one cycle and deasserts on the following edge unless a new completion occurs.
- Back-to-back operation:
  - start high in the cycle where done=1 is accepted, since busy=0 there.
  - Throughput is one result per DW cycles.
- Reset asserted mid-CALC:
  - Immediately aborts the division and forces all reset values.
  - No done pulse is produced for the aborted operation.
  - The first edge after reset deassertion samples start normally.

## Test plan
- Reset: assert rst mid-run -> all outputs 0 asynchronously. After release with start=0 -> busy=0, done=0.
- pm2 inverse set:
  - 1001/11 -> quotient 0011, remainder 00.
  - 0011/01 -> 0011 r00.
  - 0010/01 -> 0010 r00.
  - 0100/10 -> 0010 r00.
  - Each with done exactly 4 cycles after the start edge and busy high for 4 cycles.
- Non-exact operands:
  - 1111/10 -> 0111 r01.
  - 0111/11 -> 0010 r01.
  - 0000/11 -> 0000 r00.
  - div_by_zero=0 in all cases.
- Divide by zero: 1010/00 -> done 1 cycle after start, quotient 1111, remainder 00, div_by_zero=1. A following 0110/11 -> 0010 r00 with div_by_zero cleared.
- Handshake:
  - start held high through a run while dividend/divisor change to 0001/01 mid-run -> first result still uses the captured operands; no extra done.
  - start high in the done cycle -> second run accepted, done again 4 cycles later.
- Reset mid-operation:
  - Assert rst 2 cycles into 1001/11 -> no done pulse, outputs 0.
  - Then 1100/11 -> 0100 r00.
